// File: rtl/barrel_unrotator.sv
// barrel_unrotator
// Sequential rotate-left unit: undoes a rotate-right barrel shift of the same
// amount by rotating one bit position per clock. There is a single data
// register and a down-counter. Requests do not overlap. Results wait in HOLD
// until the downstream side takes them.
module barrel_unrotator #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    // A rotate amount must be able to reach every bit position and no further.
    // Otherwise the counter arithmetic would not match the rotation.
    if (WIDTH != (2 ** AMT_W)) begin : g_width_check
        $error("barrel_unrotator: WIDTH must equal 2**AMT_W");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_next_data;
    logic [AMT_W-1:0] r_cnt;
    logic [AMT_W-1:0] w_next_cnt;
    logic             w_accept;
    logic             w_take;

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_take   = out_ready && (r_state == S_HOLD);

    // Next-state, next-data and next-count selection for the control FSM
    always_comb begin
        // NOTE: every signal gets a default before the case. A path that
        // leaves a signal unassigned would otherwise infer a latch.
        w_next_state = r_state;
        w_next_data  = r_data;
        w_next_cnt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_data  = in_data;
                    w_next_cnt   = in_amt;
                    w_next_state = (in_amt == '0) ? S_HOLD : S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_next_data = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
                w_next_cnt  = r_cnt - AMT_W'(1);
                if (r_cnt == AMT_W'(1)) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_take) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, data and counter registers. An asynchronous reset aborts any
    // operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments. Every register
        // then samples pre-edge values, whatever order the statements are in.
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_data  <= w_next_data;
            r_cnt   <= w_next_cnt;
        end
    end

    // The outputs decode straight from the registered state. A reset
    // therefore shows up on them at once, without waiting for a clock edge.
    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_HOLD);
    assign out_data  = out_valid ? r_data : '0;

endmodule

// File: tb/tb_barrel_unrotator.sv
// tb_barrel_unrotator
// Directed-vector bench with a scoreboard. The driver pushes the expected
// result on every accept. A monitor running on the falling edge compares every
// presented output against the head of the queue.
module tb_barrel_unrotator;

    localparam int WIDTH = 4;
    localparam int AMT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [AMT_W-1:0] in_amt = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    barrel_unrotator #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] exp_data;
        logic [WIDTH-1:0] orig;
        logic [AMT_W-1:0] amt;
        int               exp_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference rotate-left: produces expected values for the exhaustive sweep.
    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int n);
        logic [WIDTH-1:0] r;
        r = WIDTH'((v << n) | (v >> (WIDTH - n)));
        return r;
    endfunction

    // Reference rotate-right: the shifter this block inverts.
    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input int n);
        logic [WIDTH-1:0] r;
        r = WIDTH'((v >> n) | (v << (WIDTH - n)));
        return r;
    endfunction

    // Monitor: checks the reset values, data gating, latency, results and handshakes
    logic prev_valid = 1'b0;
    logic prev_hs    = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            check("rst_busy", busy, 0);
            check("rst_in_ready", in_ready, 1);
        end else begin
            if (prev_hs) check("valid_drop", out_valid, 0);
            if (!out_valid) begin
                check("data_zero", out_data, 0);
                check("busy_state", busy, (sb.size() > 0) ? 1 : 0);
                check("in_ready_state", in_ready, (sb.size() > 0) ? 0 : 1);
            end else if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got %b expected no output (t=%0t)", out_data, $time);
            end else begin
                if (!prev_valid) check("latency_cyc", cyc, sb[0].exp_cyc);
                check("out_data", out_data, sb[0].exp_data);
                check("busy_hold", busy, 1);
                check("in_ready_hold", in_ready, 0);
                if (out_ready) begin
                    check("roundtrip", rotr(out_data, int'(sb[0].amt)), sb[0].orig);
                    void'(sb.pop_front());
                end
            end
            prev_valid = out_valid;
            prev_hs    = out_valid && out_ready;
        end
    end

    // Present a request, wait for the accept edge, then record the expectation
    task automatic send(input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a,
                        input logic [WIDTH-1:0] e);
        bit   ok;
        exp_t x;
        ok       = 1'b0;
        in_data  = d;
        in_amt   = a;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            ok = in_ready;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        in_amt   = AMT_W'($urandom);
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no accept expected accept of %b", d);
        end else begin
            x.exp_data = e;
            x.orig     = d;
            x.amt      = a;
            x.exp_cyc  = cyc + int'(a);
            sb.push_back(x);
        end
    endtask

    // Wait until the scoreboard has drained, with a bound on the wait
    task automatic wait_done();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int t;
        // Reset held with random inputs. The monitor checks the outputs.
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'($urandom);
            in_data   = WIDTH'($urandom);
            in_amt    = AMT_W'($urandom);
            out_ready = 1'($urandom);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;

        // Latency and the basic function
        send(4'b0001, 2'd1, 4'b0010); wait_done();
        send(4'b0001, 2'd3, 4'b1000); wait_done();
        send(4'b0001, 2'd2, 4'b0100); wait_done();
        send(4'b1100, 2'd0, 4'b1100); wait_done();

        // Backpressure: results hold steady and inputs are ignored
        out_ready = 1'b0;
        send(4'b1100, 2'd2, 4'b0011);
        in_valid = 1'b1;
        in_data  = 4'b1111;
        in_amt   = 2'd1;
        t = 0;
        while (!out_valid && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("bp_reach_hold", out_valid, 1);
        repeat (5) @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_done();
        @(posedge clk);
        #1;
        check("bp_idle_after", busy, 0);

        // Mid-operation reset: the abort is immediate and no result appears
        send(4'b0110, 2'd3, 4'b0011);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data", out_data, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        send(4'b0001, 2'd1, 4'b0010); wait_done();

        // Exhaustive sweep of every data value and amount
        for (int d = 0; d < 16; d++) begin
            for (int a = 0; a < 4; a++) begin
                send(WIDTH'(d), AMT_W'(a), rotl(WIDTH'(d), a));
                wait_done();
            end
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/barrel_unrotator.md
BARREL_UNROTATOR -- requirements
Module: barrel_unrotator

Interface
REQ-001 Parameter WIDTH, default 4: data word width in bits.
REQ-002 Parameter AMT_W, default 2: rotate-amount width in bits; WIDTH SHALL equal 2**AMT_W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request present on in_data/in_amt.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 in_data  input  WIDTH  word to un-rotate.
REQ-008 in_amt  input  AMT_W  rotate-left amount, 0..WIDTH-1.
REQ-009 out_valid  output  1  result present on out_data.
REQ-010 out_ready  input  1  downstream accepts result this cycle.
REQ-011 out_data  output  WIDTH  result word.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 Block SHALL compute out_data = in_data rotated left by in_amt, i.e. the inverse of the team's 4-bit rotate-right barrel shifter for the same amount.
REQ-014 Rotation SHALL be sequential: one bit position per clock, using one WIDTH-bit data register and one AMT_W-bit down-counter; no full barrel network.
REQ-015 States SHALL be IDLE, SHIFT, HOLD.
REQ-016 in_ready SHALL be 1 in IDLE and 0 in SHIFT and HOLD; requests are not overlapped.
REQ-017 Accept is in_valid && in_ready at a rising edge; on accept, data register <= in_data and counter <= in_amt.
REQ-018 On accept with in_amt == 0, next state SHALL be HOLD; with in_amt != 0, next state SHALL be SHIFT.
REQ-019 In SHIFT, each edge: data register <= {reg[WIDTH-2:0], reg[WIDTH-1]}, counter decrements by 1; when the counter is 1 before the edge, next state SHALL be HOLD.
REQ-020 Latency: for an accept at edge k, out_valid SHALL first be high in the cycle after edge k+in_amt (amt 0: cycle after accept; amt 3: three cycles later).
REQ-021 In HOLD, out_valid SHALL be 1 and out_data SHALL equal the data register, stable until accepted.
REQ-022 On out_valid && out_ready at an edge, next state SHALL be IDLE and out_valid SHALL drop the following cycle.
REQ-023 Throughput: with out_ready held high, one result per in_amt+2 cycles.
REQ-024 out_data SHALL be 0 whenever out_valid is 0.
REQ-025 in_data, in_amt and in_valid SHALL be ignored outside IDLE; out_ready SHALL be ignored outside HOLD.
REQ-026 Counter arithmetic SHALL be unsigned modulo 2**AMT_W; in_amt = WIDTH-1 (3) is the maximum and SHALL NOT wrap.

Reset
REQ-027 While rst_n is low: state IDLE, data register 0, counter 0, out_valid 0, out_data 0, busy 0, in_ready 1.
REQ-028 Reset assertion SHALL take effect immediately, without waiting for clk.
REQ-029 Reset in SHIFT or HOLD SHALL abort the operation; the aborted result SHALL never appear on out_data.
REQ-030 The first accept SHALL be possible at the first rising edge after rst_n deasserts.

Verification
REQ-031 Reset: rst_n low with random inputs -> out_valid 0, out_data 0000, busy 0, in_ready 1.
REQ-032 Latency: in_data 0001 with in_amt 1 -> 0010 one cycle after accept; in_amt 3 -> 1000 three cycles after accept; in_amt 2 -> 0100.
REQ-033 Zero amount: in_data 1100 with in_amt 0 -> out_valid in the cycle after accept, out_data 1100.
REQ-034 Backpressure: in_data 1100 with in_amt 2 -> out_data 0011. Hold out_ready low 5 cycles while driving in_valid with 1111 -> out_data stays 0011, in_ready stays 0, busy stays 1. Raise out_ready -> IDLE next cycle.
REQ-035 Mid-operation reset: in_data 0110 with in_amt 3, pulse rst_n low after 1 shift -> immediate IDLE, out_valid never asserted for 0110. Next request 0001 with in_amt 1 -> 0010.
REQ-036 Exhaustive: all 16 in_data values x 4 in_amt values. Feed each result through a rotate-right reference model with the same amount -> original in_data in every case.
